// File: rtl/multi_channel_mac.sv
// rtl/multi_channel_mac.sv - multi-lane pipelined multiply-accumulate with windowed, saturating sums
module multi_channel_mac #(
    parameter int bitwidthA      = 8,
    parameter int bitwidthB      = 8,
    parameter int CHANNELS       = 4,
    parameter int AccCycles      = 400,
    parameter int bitwidthAccRes = 25,
    parameter int SIGNED         = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               in_valid,
    input  logic                               in_last,
    input  logic [CHANNELS*bitwidthA-1:0]      operandA,
    input  logic [CHANNELS*bitwidthB-1:0]      operandB,
    output logic [CHANNELS*bitwidthAccRes-1:0] AccResult,
    output logic [CHANNELS-1:0]                overflow,
    output logic                               out_valid,
    output logic                               busy
);

    localparam int PW = bitwidthA + bitwidthB;
    localparam int W  = bitwidthAccRes;
    localparam int CW = (AccCycles > 1) ? $clog2(AccCycles) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(AccCycles - 1);

    if (W < PW) begin : g_width_check
        $error("bitwidthAccRes must be at least bitwidthA+bitwidthB");
    end
    if (AccCycles < 1) begin : g_window_check
        $error("AccCycles must be at least 1");
    end

    logic [CW-1:0]                 count;
    logic [CHANNELS*bitwidthA-1:0] a1;
    logic [CHANNELS*bitwidthB-1:0] b1;
    logic                          v1, last1, v2, last2;
    logic [PW-1:0]                 prod_c [CHANNELS];
    logic [PW-1:0]                 prod_r [CHANNELS];
    logic [W-1:0]                  ext    [CHANNELS];
    logic [W-1:0]                  acc    [CHANNELS];
    logic [W-1:0]                  sat_val[CHANNELS];
    logic [CHANNELS-1:0]           sat;
    logic [CHANNELS-1:0]           ovf;

    // Stages 1 and 2: operand capture, window counting and multiply
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            v1    <= 1'b0;
            last1 <= 1'b0;
            v2    <= 1'b0;
            last2 <= 1'b0;
        end else if (enable) begin
            v1    <= in_valid;
            last1 <= in_valid & (in_last | (count == LAST_COUNT));
            if (in_valid) begin
                a1    <= operandA;
                b1    <= operandB;
                count <= (in_last | (count == LAST_COUNT)) ? '0 : count + 1'b1;
            end
            v2    <= v1;
            last2 <= last1;
            if (v1) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    prod_r[i] <= prod_c[i];
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic [PW-1:0] ea, eb;
        logic [W:0]    sum;

        // Low PW bits of the product are identical for signed and unsigned once operands are extended
        if (SIGNED != 0) begin : g_signed
            assign ea     = PW'($signed(a1[i*bitwidthA +: bitwidthA]));
            assign eb     = PW'($signed(b1[i*bitwidthB +: bitwidthB]));
            assign ext[i] = W'($signed(prod_r[i]));
            assign sum    = {acc[i][W-1], acc[i]} + {ext[i][W-1], ext[i]};
            assign sat[i] = sum[W] ^ sum[W-1];
            assign sat_val[i] = !sat[i] ? sum[W-1:0] :
                                sum[W]  ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin : g_unsigned
            assign ea     = PW'(a1[i*bitwidthA +: bitwidthA]);
            assign eb     = PW'(b1[i*bitwidthB +: bitwidthB]);
            assign ext[i] = W'(prod_r[i]);
            assign sum    = {1'b0, acc[i]} + {1'b0, ext[i]};
            assign sat[i] = sum[W];
            assign sat_val[i] = sat[i] ? {W{1'b1}} : sum[W-1:0];
        end

        assign prod_c[i] = ea * eb;
    end

    // Stage 3: saturating accumulate; a window end publishes the sum and restarts from zero
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf       <= '0;
            AccResult <= '0;
            overflow  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= enable & v2 & last2;
            if (enable && v2) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (last2) begin
                        AccResult[i*W +: W] <= sat_val[i];
                        overflow[i]         <= ovf[i] | sat[i];
                        acc[i]              <= '0;
                        ovf[i]              <= 1'b0;
                    end else begin
                        acc[i] <= sat_val[i];
                        ovf[i] <= ovf[i] | sat[i];
                    end
                end
            end
        end
    end

    assign busy = (count != '0) | v1 | v2;

endmodule
